// File: rtl/counter_sequencer.sv
// Start/pause/abort sequenced up-counter: counts from 0 to a latched limit,
// pulses done for one cycle and keeps a saturating count of completed runs.
module counter_sequencer #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    output logic             cnt_en,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       run_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] cnt_inc;
    logic             load;

    assign cnt_inc = cnt_out + ONE;

    // A new run (limit latched, count cleared) starts from IDLE on start, or
    // straight out of DONE when auto-reload is enabled.
    assign load = !abort && ((state == S_IDLE && start) ||
                             (state == S_DONE && AUTO_RELOAD != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!abort && start) begin
                    next_state = (limit == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (pause) begin
                    next_state = S_PAUSE;
                end else if (cnt_inc == limit_q) begin
                    next_state = S_DONE;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (!pause) begin
                    next_state = S_RUN;
                end
            end
            S_DONE: begin
                if (abort || AUTO_RELOAD == 0) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = (limit == '0) ? S_DONE : S_RUN;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_en    = (state == S_RUN) && !pause && !abort;
        state_dbg = state;
    end

    // busy/done are registered from next_state so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_out <= '0;
            limit_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            run_cnt <= 8'd0;
        end else begin
            if (abort) begin
                cnt_out <= '0;
            end else if (load) begin
                cnt_out <= '0;
                limit_q <= limit;
            end else if (cnt_en) begin
                cnt_out <= cnt_inc;
            end
            busy <= (next_state == S_RUN) || (next_state == S_PAUSE);
            done <= (next_state == S_DONE);
            if (next_state == S_DONE && run_cnt != 8'hff) begin
                run_cnt <= run_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed steps push expected outputs into a
// queue per instance; a monitor pops and compares after every rising edge.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, pause0 = 1'b0, abort0 = 1'b0;
    logic       start1 = 1'b0, pause1 = 1'b0, abort1 = 1'b0;
    logic [3:0] limit0 = 4'd0, limit1 = 4'd0;
    logic       cnt_en0, busy0, done0, cnt_en1, busy1, done1;
    logic [3:0] cnt_out0, cnt_out1;
    logic [7:0] run_cnt0, run_cnt1;
    logic [1:0] state0, state1;
    logic       en_s0 = 1'b0, en_s1 = 1'b0;

    // packed expectation: {cnt_en, done, busy, run_cnt[7:0], cnt_out[3:0]}
    logic [14:0] exp_q0[$];
    logic [14:0] exp_q1[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(4), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pause(pause0), .abort(abort0),
        .limit(limit0), .cnt_en(cnt_en0), .cnt_out(cnt_out0), .busy(busy0),
        .done(done0), .run_cnt(run_cnt0), .state_dbg(state0)
    );

    counter_sequencer #(.WIDTH(4), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pause(pause1), .abort(abort1),
        .limit(limit1), .cnt_en(cnt_en1), .cnt_out(cnt_out1), .busy(busy1),
        .done(done1), .run_cnt(run_cnt1), .state_dbg(state1)
    );

    function automatic logic [14:0] pack(input logic [3:0] c, input logic b, input logic d,
                                         input logic [7:0] r, input logic e);
        return {e, d, b, r, c};
    endfunction

    task automatic compare(input string name, input logic [14:0] got, input logic [14:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got cnt=%0d busy=%0d done=%0d run=%0d en=%0d want cnt=%0d busy=%0d done=%0d run=%0d en=%0d",
                     name, got[3:0], got[12], got[13], got[11:4], got[14],
                     want[3:0], want[12], want[13], want[11:4], want[14]);
        end
    endtask

    // cnt_en is combinational: capture it mid-cycle, before the edge it qualifies.
    initial forever begin
        @(negedge clk);
        #3;
        en_s0 = cnt_en0;
        en_s1 = cnt_en1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q0.size() > 0)
            compare("dut0_step", pack(cnt_out0, busy0, done0, run_cnt0, en_s0), exp_q0.pop_front());
        if (exp_q1.size() > 0)
            compare("dut1_step", pack(cnt_out1, busy1, done1, run_cnt1, en_s1), exp_q1.pop_front());
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input int d, input logic s, input logic p, input logic a,
                        input logic [3:0] l, input logic [3:0] ec, input logic eb,
                        input logic ed, input logic [7:0] er, input logic een);
        @(negedge clk);
        #1;
        if (d == 0) begin
            start0 = s; pause0 = p; abort0 = a; limit0 = l;
            exp_q0.push_back(pack(ec, eb, ed, er, een));
        end else begin
            start1 = s; pause1 = p; abort1 = a; limit1 = l;
            exp_q1.push_back(pack(ec, eb, ed, er, een));
        end
    endtask

    initial begin
        start0 = 1'b1;
        limit0 = 4'd5;
        #1;
        // async reset: outputs already cleared before any clock edge
        compare("reset_async0", pack(cnt_out0, busy0, done0, run_cnt0, 1'b0), 15'd0);
        compare("reset_async1", pack(cnt_out1, busy1, done1, run_cnt1, 1'b0), 15'd0);
        repeat (2) @(posedge clk);
        #2;
        compare("reset_start_held", pack(cnt_out0, busy0, done0, run_cnt0, 1'b0), 15'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        start0 = 1'b0;
        step(0, 0, 0, 0, 5, 0, 0, 0, 0, 0);

        // limit=5 plain run
        step(0, 1, 0, 0, 5, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 5, 4'(i), 1, 0, 0, 1);
        step(0, 0, 0, 0, 5, 5, 0, 1, 1, 1);
        step(0, 0, 0, 0, 5, 5, 0, 0, 1, 0);
        step(0, 0, 0, 0, 5, 5, 0, 0, 1, 0);

        // limit=8 with a 3-cycle pause at count 3
        step(0, 1, 0, 0, 8, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 8, 4'(i), 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8, 3, 1, 0, 1, 0);
        step(0, 0, 0, 0, 8, 3, 1, 0, 1, 0);
        for (int i = 4; i <= 7; i++) step(0, 0, 0, 0, 8, 4'(i), 1, 0, 1, 1);
        step(0, 0, 0, 0, 8, 8, 0, 1, 2, 1);
        step(0, 0, 0, 0, 8, 8, 0, 0, 2, 0);

        // limit=10 aborted at count 6, start on the abort cycle ignored
        step(0, 1, 0, 0, 10, 0, 1, 0, 2, 0);
        for (int i = 1; i <= 6; i++) step(0, 0, 0, 0, 10, 4'(i), 1, 0, 2, 1);
        step(0, 1, 0, 1, 10, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 10, 0, 0, 0, 2, 0);

        // limit=0: done right after start
        step(0, 1, 0, 0, 0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

        // limit=15: no wrap; start and limit changes mid-run ignored
        step(0, 1, 0, 0, 15, 0, 1, 0, 3, 0);
        for (int i = 1; i <= 15; i++)
            step(0, (i == 5), 0, 0, 3, 4'(i), (i < 15), (i == 15), (i == 15) ? 8'd4 : 8'd3, 1);
        step(0, 0, 0, 0, 3, 15, 0, 0, 4, 0);
        step(0, 0, 0, 1, 3, 0, 0, 0, 4, 0);

        // auto-reload, limit=3, 300 back-to-back runs
        step(1, 1, 0, 0, 3, 0, 1, 0, 0, 0);
        for (int r = 1; r <= 300; r++) begin
            step(1, 0, 0, 0, 3, 1, 1, 0, (r - 1 > 255) ? 8'd255 : 8'(r - 1), 1);
            step(1, 0, 0, 0, 3, 2, 1, 0, (r - 1 > 255) ? 8'd255 : 8'(r - 1), 1);
            step(1, 0, 0, 0, 3, 3, 0, 1, (r > 255) ? 8'd255 : 8'(r), 1);
            if (r < 300)
                step(1, 0, 0, 0, 3, 0, 1, 0, (r > 255) ? 8'd255 : 8'(r), 0);
        end
        step(1, 0, 0, 0, 3, 0, 1, 0, 255, 0);
        step(1, 0, 0, 0, 3, 1, 1, 0, 255, 1);

        // async reset mid-run clears everything immediately
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("midrun_reset1", pack(cnt_out1, busy1, done1, run_cnt1, cnt_en1), 15'd0);
        compare("midrun_reset0", pack(cnt_out0, busy0, done0, run_cnt0, cnt_en0), 15'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 3, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 3, 1, 1, 0, 0, 1);

        @(posedge clk);
        #2;
        total++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d/%0d left want 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: width of the sequenced up-counter and of limit.
REQ-002 Parameter AUTO_RELOAD, default 0: 1 = restart automatically after each completed run.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: begin a run; sampled only in IDLE.
REQ-006 Port pause, input, 1: level; hold the count while a run is active.
REQ-007 Port abort, input, 1: cancel the active run.
REQ-008 Port limit, input, WIDTH: terminal count; latched at run start.
REQ-009 Port cnt_en, output, 1: combinational increment qualifier for the counter stage.
REQ-010 Port cnt_out, output, WIDTH: current count.
REQ-011 Port busy, output, 1: high in RUN or PAUSE.
REQ-012 Port done, output, 1: one-cycle pulse on run completion.
REQ-013 Port run_cnt, output, 8: number of completed runs, saturating.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE; all outputs except cnt_en SHALL be registered.
REQ-015 Input priority SHALL be abort > pause > count/start.
REQ-016 IDLE behaviour:
- start=1 with limit!=0: latch limit into limit_q, clear cnt_out to 0, go to RUN.
- start=1 with limit==0: clear cnt_out, go directly to DONE.
REQ-017 RUN behaviour:
- cnt_en = (state==RUN) & ~pause & ~abort.
- cnt_out increments by 1 on each edge where cnt_en=1.
- The edge on which cnt_out becomes limit_q SHALL move the FSM to DONE.
REQ-018 RUN with pause=1 SHALL move to PAUSE with no increment on that edge.
REQ-019 PAUSE SHALL hold cnt_out and return to RUN on the first edge that samples pause=0; the increment resumes on the following edge.
REQ-020 abort=1 in RUN, PAUSE or DONE SHALL go to IDLE on the next edge:
- cnt_out cleared to 0.
- No done pulse.
- run_cnt unchanged.
REQ-021 done SHALL be 1 exactly while in DONE; DONE lasts one cycle.
REQ-022 run_cnt SHALL increment on entry to DONE and saturate at 255.
REQ-023 From DONE with AUTO_RELOAD=0, the FSM SHALL go to IDLE, with cnt_out holding limit_q until the next start or abort.
REQ-024 From DONE with AUTO_RELOAD=1, the FSM SHALL clear cnt_out, re-latch limit and go to RUN (or to DONE again if limit==0).
REQ-025 start outside IDLE SHALL be ignored, and limit changes during a run SHALL have no effect.
REQ-026 cnt_out SHALL never wrap; with limit=2^WIDTH-1 the run stops at the all-ones value.
REQ-027 Run latency: with start sampled at edge k and no pause, DONE SHALL be entered at edge k+limit and done SHALL be high for cycle k+limit.

Reset
REQ-028 rst=1 SHALL immediately force, without waiting for a clock edge:
- state IDLE,
- cnt_out=0, busy=0, done=0, run_cnt=0, limit_q=0.
REQ-029 Reset asserted mid-run SHALL abandon the run with no done pulse, and operation SHALL resume from IDLE on the first edge after rst deasserts.

Verification
REQ-030 Reset: assert rst between clock edges -> all outputs 0 before the next edge; start held during reset is ignored.
REQ-031 limit=5, 1-cycle start -> cnt_out 0,1,2,3,4,5; busy high 5 cycles; done high 1 cycle with cnt_out=5; run_cnt=1; IDLE holding 5.
REQ-032 limit=8, pause high 3 cycles at cnt_out=3 -> cnt_out holds 3 through PAUSE; done 4 cycles later than the unpaused run (3 pause cycles + 1 resume cycle); cnt_en=0 throughout the pause.
REQ-033 limit=10, abort at cnt_out=6 -> next edge IDLE, cnt_out=0, done never asserted, run_cnt unchanged; a start on the same cycle as abort is ignored.
REQ-034 Boundaries: limit=0 -> done the cycle after start with cnt_out=0; limit=15 -> cnt_out reaches 15, no wrap to 0 while busy.
REQ-035 AUTO_RELOAD=1, limit=3 -> repeating pattern 0,1,2,3(done),0,1,2,3(done); run_cnt saturates at 255 after 300 runs; async rst mid-run clears everything.
